// File: rtl/vco_adc_ctrl.sv
// ---------------------------------------------------------------------------
// vco_adc_ctrl
//
// Conversion sequencer for the VCO-based ADC macro. It enables the
// oscillator (active-low enb), waits a programmable settle time, then counts
// rising edges of the VCO phase output over a programmable window of clk
// cycles. Each window count is offered as one sample on a valid/ready stream.
// Single-shot and continuous modes are supported, plus abort.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   start         one-cycle conversion request (ignored while busy)
//   cont          continuous mode level, sampled at each window end
//   abort         stop immediately and return to IDLE
//   cfg_settle    settle length in cycles, latched on accepted start
//   cfg_win       window length in cycles, latched on accepted start (0 -> 1)
//   vco_p         VCO phase output, asynchronous to clk
//   vco_enb       VCO enable pin, 0 = oscillator running
//   busy          high in SETTLE or CONVERT
//   sample_data   edge count of the last completed window
//   sample_valid  sample available
//   sample_ready  consumer accepts the sample
//   overrun       one-cycle pulse when an unaccepted sample is overwritten
// ---------------------------------------------------------------------------
module vco_adc_ctrl #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16,
    parameter int SET_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic [SET_W-1:0] cfg_settle,
    input  logic [WIN_W-1:0] cfg_win,
    input  logic             vco_p,
    output logic             vco_enb,
    output logic             busy,
    output logic [CNT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT
    } state_t;

    state_t             state_reg;
    logic [2:0]         sync_reg;        // [0]=s1, [1]=s2, [2]=s3 (history)
    logic [SET_W-1:0]   settle_cnt_reg;
    logic [WIN_W-1:0]   win_len_reg;     // latched window length, reused in continuous mode
    logic [WIN_W-1:0]   win_cnt_reg;
    logic [CNT_W-1:0]   edge_cnt_reg;
    logic [CNT_W-1:0]   sample_data_reg;
    logic               sample_valid_reg;
    logic               overrun_reg;
    logic               vco_enb_reg;
    logic               busy_reg;

    logic               edge_det;
    logic [WIN_W-1:0]   win_eff;
    logic [CNT_W-1:0]   cnt_next;

    // Rising edge of the synchronized phase signal; two cycles of latency.
    assign edge_det = sync_reg[1] & ~sync_reg[2];

    // A zero window length behaves as a one-cycle window.
    assign win_eff = (cfg_win == '0) ? WIN_W'(1) : cfg_win;

    // Count including this cycle's edge, saturating at all-ones. Used both
    // for the running count and for the final sample so a last-cycle edge
    // is never lost.
    assign cnt_next = (edge_det && (edge_cnt_reg != '1)) ? edge_cnt_reg + CNT_W'(1)
                                                        : edge_cnt_reg;

    // Two-flop synchronizer plus history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], vco_p};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            settle_cnt_reg   <= '0;
            win_len_reg      <= '0;
            win_cnt_reg      <= '0;
            edge_cnt_reg     <= '0;
            sample_data_reg  <= '0;
            sample_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            vco_enb_reg      <= 1'b1;
            busy_reg         <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;

            // Consumer handshake; a sample load below overrides this clear.
            if (sample_valid_reg && sample_ready) begin
                sample_valid_reg <= 1'b0;
            end

            if (abort) begin
                // Partial count is dropped; the output register is left alone.
                state_reg      <= ST_IDLE;
                settle_cnt_reg <= '0;
                win_cnt_reg    <= '0;
                edge_cnt_reg   <= '0;
                vco_enb_reg    <= 1'b1;
                busy_reg       <= 1'b0;
            end else begin
                unique case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            win_len_reg <= win_eff;
                            vco_enb_reg <= 1'b0;
                            busy_reg    <= 1'b1;
                            if (cfg_settle != '0) begin
                                state_reg      <= ST_SETTLE;
                                settle_cnt_reg <= cfg_settle;
                            end else begin
                                state_reg    <= ST_CONVERT;
                                win_cnt_reg  <= win_eff;
                                edge_cnt_reg <= '0;
                            end
                        end
                    end

                    ST_SETTLE: begin
                        settle_cnt_reg <= settle_cnt_reg - SET_W'(1);
                        if (settle_cnt_reg == SET_W'(1)) begin
                            state_reg    <= ST_CONVERT;
                            win_cnt_reg  <= win_len_reg;
                            edge_cnt_reg <= '0;
                        end
                    end

                    ST_CONVERT: begin
                        if (win_cnt_reg == WIN_W'(1)) begin
                            // Window end: publish the count.
                            sample_data_reg  <= cnt_next;
                            sample_valid_reg <= 1'b1;
                            overrun_reg      <= sample_valid_reg & ~sample_ready;
                            edge_cnt_reg     <= '0;
                            if (cont) begin
                                // Back-to-back window, oscillator stays on.
                                win_cnt_reg <= win_len_reg;
                            end else begin
                                state_reg   <= ST_IDLE;
                                win_cnt_reg <= '0;
                                vco_enb_reg <= 1'b1;
                                busy_reg    <= 1'b0;
                            end
                        end else begin
                            win_cnt_reg  <= win_cnt_reg - WIN_W'(1);
                            edge_cnt_reg <= cnt_next;
                        end
                    end

                    default: begin
                        state_reg   <= ST_IDLE;
                        vco_enb_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign vco_enb      = vco_enb_reg;
    assign busy         = busy_reg;
    assign sample_data  = sample_data_reg;
    assign sample_valid = sample_valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: doc/vco_adc_ctrl.md
# vco_adc_ctrl

Conversion sequencer for the VCO-based ADC macro. It enables the oscillator through its active-low `enb` pin and waits a programmable settle time. It then counts rising edges of the VCO phase output `p` over a programmable window of `clk` cycles. Each window count is presented as one sample on a valid/ready stream to the digital decimation path. Single-shot and continuous modes are supported, plus abort.

## Interface
Parameters:
- `CNT_W`, 16: sample (edge count) width
- `WIN_W`, 16: window length field width
- `SET_W`, 8: settle length field width

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high; clock is `clk`
- `start`  in  1  one-cycle request to begin a conversion; ignored while `busy`=1
- `cont`  in  1  level; continuous mode, sampled at each window end
- `abort`  in  1  stop immediately and return to IDLE
- `cfg_settle`  in  SET_W  settle cycles, latched on accepted `start`
- `cfg_win`  in  WIN_W  window cycles, latched on accepted `start`; 0 is treated as 1
- `vco_p`  in  1  VCO phase output; asynchronous to `clk`
- `vco_enb`  out  1  drives the VCO `enb` pin; 0 = oscillator running
- `busy`  out  1  1 in SETTLE or CONVERT
- `sample_data`  out  CNT_W  edge count of the last completed window
- `sample_valid`  out  1  sample available
- `sample_ready`  in  1  consumer accepts the sample
- `overrun`  out  1  one-cycle pulse when an unaccepted sample is overwritten

## Operation
- **Input conditioning:** `vco_p` passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - `edge` = s2 & ~s3.
  - The synchronizer stages are reset to 0.
- **State register:** IDLE, SETTLE, CONVERT. All outputs are registered.
- **IDLE:** `vco_enb`=1, `busy`=0.
  - On `start`: latch cfg_settle→S and max(cfg_win,1)→W.
  - If S>0, go to SETTLE with the down-counter loaded to S. If S=0, go directly to CONVERT.
- **SETTLE:** `vco_enb`=0. Lasts exactly S cycles, then goes to CONVERT. Edges are not counted.
- **CONVERT:** `vco_enb`=0. Lasts exactly W cycles.
  - The edge counter clears on entry.
  - The counter increments on every CONVERT cycle with `edge`=1, including the last cycle.
  - The counter saturates at 2^CNT_W−1.
- **Window end (last CONVERT cycle):**
  - The final count (including any last-cycle edge) loads `sample_data`, and `sample_valid` is set.
  - If `cont`=1: re-enter CONVERT next cycle with the counter cleared and the window reloaded from the latched W. There is no re-settle, and `vco_enb` stays 0.
  - If `cont`=0: go to IDLE.
- **Output register:**
  - `sample_valid` clears on the cycle after `sample_valid`&`sample_ready`.
  - If a new sample loads on the same cycle as an accept, `sample_valid` stays 1 with the new data and there is no overrun.
  - If a new sample loads while `sample_valid`=1 and `sample_ready`=0, the data is overwritten and `overrun` pulses for 1 cycle.
- **abort (any state):**
  - Next cycle: IDLE, `vco_enb`=1, `busy`=0.
  - The partial count is discarded. The output register and `sample_valid` are untouched.
  - abort has priority over `start` and over window end: an abort on the last CONVERT cycle produces no sample.
- **Reset:** state IDLE, `vco_enb`=1, `busy`=0, `sample_valid`=0, `sample_data`=0, `overrun`=0. All counters are 0.

## Timing
- Accepted `start` at cycle 0 gives:
  - SETTLE during cycles 1..S.
  - CONVERT during cycles S+1..S+W.
  - `vco_enb`=0 from cycle 1.
  - `sample_valid`=1 at cycle S+W+1.
  - In single shot, `vco_enb`=1 and `busy`=0 also at cycle S+W+1.
- Continuous mode: one sample every W cycles, back-to-back, with no dead cycle.
- Edge latency: a `vco_p` 0→1 seen at edge n gives `edge`=1 in cycle n+2. The counted window is therefore the input shifted by 2 cycles.
- `start` while `busy` is ignored; the latched config does not change.
- `cont` deasserted mid-window stops the run after the current window completes.

## Test plan
1. **Reset:** assert `rst` for 3 cycles -> `vco_enb`=1, `busy`=0, `sample_valid`=0, `sample_data`=0, `overrun`=0.
2. **Single shot:** `vco_p` toggles every cycle, S=4, W=10, `sample_ready`=1, start at cycle 0 -> `vco_enb` low during cycles 1..14; `sample_valid` at cycle 15 with `sample_data`=5; `vco_enb`=1 and `busy`=0 at cycle 15.
3. **Saturation:** CNT_W=4, S=0, W=40, toggling `vco_p` -> `sample_data`=15; CONVERT begins at cycle 1.
4. **Continuous with stalled consumer:** W=8, `cont`=1, `sample_ready`=0.
   - Expected: samples at cycles S+9 and S+17; `overrun` pulses at S+17; data = second count.
   - Repeat with `sample_ready`=1: no overrun, and `sample_valid` rises every 8 cycles.
5. **Abort:** abort in the 3rd CONVERT cycle -> IDLE and `vco_enb`=1 next cycle; no `sample_valid`. A fresh start afterwards counts from 0.
6. **Boundary:** `cfg_win`=0 -> one-cycle window.
   - Constant `vco_p`=1 gives count 0.
   - A `start` issued during SETTLE is ignored (cycle timing is unchanged).
